// File: rtl/bist_response_analyzer_pkg.sv
// Shared BIST package: FSM state encoding, default MISR constants and
// the counter-width helper used by the response analyzer.
package bist_response_analyzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_COMPACT = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } bra_state_t;

  localparam logic [7:0] BRA_DEF_POLY   = 8'h1D;
  localparam logic [7:0] BRA_DEF_SEED   = 8'h00;
  localparam logic [7:0] BRA_DEF_GOLDEN = 8'h00;

  // Sample counter must reach NSAMPLES+1 so an overrun saturates above the
  // expected count instead of wrapping back onto it.
  function automatic int bra_cnt_w(input int nsamples);
    return $clog2(nsamples + 2);
  endfunction

endpackage

// File: rtl/bist_response_analyzer_misr.sv
// bra_misr: multiple-input signature register. Shifts left, folds POLY in
// when the outgoing MSB is set, and XORs in the parallel data word.
module bra_misr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_nxt;

  // Next signature for one compaction step.
  always_comb begin
    sig_nxt = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
  end

  // Signature register: seed is a tied-off constant, so it doubles as the
  // reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sig <= seed;
    else if (load)   sig <= seed;
    else if (enable) sig <= sig_nxt;
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: compacts CUT responses into a MISR while running,
// compares signature and sample count against golden values on finish, and
// hands pass/fail to the host over a valid/ack handshake.
// Optional macro BRA_SIG_OUT_EN exposes the live signature and sample count.
module bist_response_analyzer
  import bist_response_analyzer_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(BRA_DEF_POLY),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(BRA_DEF_SEED),
  parameter logic [WIDTH-1:0] GOLDEN   = WIDTH'(BRA_DEF_GOLDEN),
  parameter int               NSAMPLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_data,
  input  logic             result_ack,
  output logic             result_valid,
  output logic             pass,
  output logic             fail
`ifdef BRA_SIG_OUT_EN
  ,
  output logic [WIDTH-1:0]                   signature,
  output logic [bra_cnt_w(NSAMPLES)-1:0]     sample_count
`endif
);

  localparam int            CW      = bra_cnt_w(NSAMPLES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_EXP = CW'(NSAMPLES);

  bra_state_t       state, state_nxt;
  logic [WIDTH-1:0] sig;
  logic [CW-1:0]    count;
  logic             misr_load, misr_en, match;

  assign misr_load = (state == ST_SEED);
  assign misr_en   = (state == ST_COMPACT) && running;
  assign match     = (sig == GOLDEN) && (count == CNT_EXP);

  // Next-state: init restarts from any state; otherwise normal sequencing.
  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = ST_SEED;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_IDLE;
        ST_SEED:    state_nxt = ST_COMPACT;
        ST_COMPACT: if (finish) state_nxt = ST_COMPARE;
        ST_COMPARE: state_nxt = ST_DONE;
        ST_DONE:    if (result_ack) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  bra_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .load   (misr_load),
    .seed   (SEED),
    .enable (misr_en),
    .data   (cut_data),
    .sig    (sig)
  );

  // Sample counter: cleared in SEED, saturates so overruns never alias.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          count <= '0;
    else if (misr_load)                  count <= '0;
    else if (misr_en && count != CNT_MAX) count <= count + 1'b1;
  end

  // Result handshake: latched in COMPARE, held through DONE until ack;
  // init discards any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
    end else if (init) begin
      result_valid <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
    end else if (state == ST_COMPARE) begin
      result_valid <= 1'b1;
      pass         <= match;
      fail         <= !match;
    end else if (state == ST_DONE && result_ack) begin
      result_valid <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
    end
  end

`ifdef BRA_SIG_OUT_EN
  assign signature    = sig;
  assign sample_count = count;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Testbench for bist_response_analyzer (WIDTH=4, POLY=3, SEED=0, GOLDEN=1,
// NSAMPLES=5): directed scenarios plus randomized sequences checked against
// an arithmetic model of the signature and an unbounded sample count.
module tb_bist_response_analyzer;

  localparam int         W  = 4;
  localparam logic [3:0] P  = 4'h3;
  localparam logic [3:0] SD = 4'h0;
  localparam logic [3:0] G  = 4'h1;
  localparam int         NS = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         init = 1'b0;
  logic         running = 1'b0;
  logic         finish = 1'b0;
  logic         result_ack = 1'b0;
  logic [W-1:0] cut_data = '0;
  logic         result_valid, pass, fail;
`ifdef BRA_SIG_OUT_EN
  logic [W-1:0] signature;
  logic [2:0]   sample_count;
`endif

  int n_asrt = 0;
  int n_fail = 0;
  int m_sig  = 0;
  int m_cnt  = 0;

  bist_response_analyzer #(
    .WIDTH    (W),
    .POLY     (P),
    .SEED     (SD),
    .GOLDEN   (G),
    .NSAMPLES (NS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .running      (running),
    .finish       (finish),
    .cut_data     (cut_data),
    .result_ack   (result_ack),
    .result_valid (result_valid),
    .pass         (pass),
    .fail         (fail)
`ifdef BRA_SIG_OUT_EN
    ,
    .signature    (signature),
    .sample_count (sample_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One compaction step as plain arithmetic on a 4-bit value.
  function automatic int step(input int s, input int d);
    return ((s * 2) % 16) ^ ((s >= 8) ? int'(P) : 0) ^ d;
  endfunction

  task automatic start();
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    m_sig = int'(SD);
    m_cnt = 0;
  endtask

  task automatic feed(input int d, input bit with_fin);
    running  = 1'b1;
    cut_data = d[W-1:0];
    finish   = with_fin;
    tick();
    running  = 1'b0;
    finish   = 1'b0;
    m_sig    = step(m_sig, d);
    m_cnt++;
`ifdef BRA_SIG_OUT_EN
    chk("signature", 32'(signature), 32'(m_sig));
`endif
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      cut_data = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic do_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  // Called right after the finish edge: nothing yet, result one edge later.
  task automatic result(input string tag);
    bit exp_pass;
    exp_pass = (m_sig == int'(G)) && (m_cnt == NS);
    chk({tag, ".rv_early"}, 32'(result_valid), 32'd0);
    tick();
    chk({tag, ".rv"},   32'(result_valid), 32'd1);
    chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, ".fail"}, 32'(fail), 32'(!exp_pass));
  endtask

  task automatic ack_it(input string tag);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk({tag, ".ack_rv"},   32'(result_valid), 32'd0);
    chk({tag, ".ack_pass"}, 32'(pass), 32'd0);
    chk({tag, ".ack_fail"}, 32'(fail), 32'd0);
  endtask

  task automatic pass_path(input string tag);
    start();
    for (int i = 1; i <= 5; i++) feed(i, 1'b0);
    do_finish();
    result(tag);
  endtask

  initial begin
    int  n, d;
    bit  force_g, fin;

    // Reset state, before any clock edge
    #3;
    chk("rst.rv",   32'(result_valid), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    chk("rst.fail", 32'(fail), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Pass path, then handshake: valid held 10 cycles without ack
    pass_path("pass");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold.rv",   32'(result_valid), 32'd1);
      chk("hold.pass", 32'(pass), 32'd1);
    end
    ack_it("pass");

    // finish seen in IDLE is ignored
    do_finish();
    tick();
    tick();
    chk("idle_fin.rv", 32'(result_valid), 32'd0);

    // Corrupted third datum
    start();
    feed(1, 1'b0); feed(2, 1'b0); feed(7, 1'b0); feed(4, 1'b0); feed(5, 1'b0);
    do_finish();
    result("corrupt");
    ack_it("corrupt");

    // Too few samples
    start();
    for (int i = 1; i <= 4; i++) feed(i, 1'b0);
    do_finish();
    result("short");
    ack_it("short");

    // Last sample on the finish cycle still gets compacted
    start();
    for (int i = 1; i <= 4; i++) feed(i, 1'b0);
    feed(5, 1'b1);
    result("fin_same");
    ack_it("fin_same");

    // Abort after 2 samples, then a full pass path
    start();
    feed(1, 1'b0); feed(2, 1'b0);
    pass_path("abort");
    ack_it("abort");

    // init in DONE beats a same-cycle ack and discards the result
    pass_path("ovr_pre");
    init = 1'b1;
    result_ack = 1'b1;
    tick();
    init = 1'b0;
    result_ack = 1'b0;
    chk("ovr.rv",   32'(result_valid), 32'd0);
    chk("ovr.pass", 32'(pass), 32'd0);
    tick();
    m_sig = int'(SD);
    m_cnt = 0;
    for (int i = 1; i <= 5; i++) feed(i, 1'b0);
    do_finish();
    result("ovr");
    ack_it("ovr");

    // Reset mid-COMPACT, then a pass path
    start();
    feed(1, 1'b0); feed(2, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.rv",   32'(result_valid), 32'd0);
    chk("rst_mid.fail", 32'(fail), 32'd0);
    #1 reset = 1'b1;
    tick();
    pass_path("rst_mid_after");

    // Reset while a result is pending clears it without a clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_done.rv",   32'(result_valid), 32'd0);
    chk("rst_done.pass", 32'(pass), 32'd0);
    #1 reset = 1'b1;
    tick();

    // Overrun: 13 samples reaching the golden signature must still fail
    start();
    for (int i = 0; i < 13; i++) begin
      d = (i == 12) ? (int'(G) ^ step(m_sig, 0)) : int'($urandom_range(0, 15));
      feed(d, 1'b0);
    end
    do_finish();
    result("overrun");
    ack_it("overrun");

    // Exactly 5 samples with idle gaps, forced to golden
    start();
    for (int i = 0; i < 5; i++) begin
      idle_gap($urandom_range(0, 2));
      d = (i == 4) ? (int'(G) ^ step(m_sig, 0)) : int'($urandom_range(0, 15));
      feed(d, 1'b0);
    end
    do_finish();
    result("gaps");
    ack_it("gaps");

    // Randomized sequences
    for (int it = 0; it < 12; it++) begin
      n       = $urandom_range(2, 8);
      force_g = 1'($urandom_range(0, 1));
      fin     = 1'b0;
      start();
      for (int i = 0; i < n; i++) begin
        idle_gap($urandom_range(0, 2));
        d = $urandom_range(0, 15);
        if (i == n - 1 && force_g) d = int'(G) ^ step(m_sig, 0);
        fin = (i == n - 1) && ($urandom_range(0, 1) == 1);
        feed(d, fin);
      end
      if (!fin) do_finish();
      result($sformatf("rnd%0d", it));
      ack_it($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
